// File: rtl/a5_pkg.sv
// Shared definitions for the A5/1 keystream controller: FSM states, lane
// geometry and the per-phase cycle counts.
package a5_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_KEY,
      ST_FRAME,
      ST_MIX,
      ST_STREAM
   } state_e;

   localparam int R1_LEN = 19;
   localparam int R2_LEN = 22;
   localparam int R3_LEN = 23;

   // Tap masks select the bits XORed into the feedback (R1: 13,16,17,18;
   // R2: 20,21; R3: 7,20,21,22).
   localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
   localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
   localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

   localparam int R1_CLK = 8;
   localparam int R2_CLK = 10;
   localparam int R3_CLK = 10;

   localparam int KEY_CYCLES   = 64;
   localparam int FRAME_CYCLES = 22;
   localparam int MIX_COUNT    = 101;
   localparam int KS_COUNT     = 228;

   localparam int CNT_W = 9;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/a5_lfsr_lane.sv
// One A5/1 LFSR lane: shifts left, new bit = d ^ parity(taps), output is the MSB.
module a5_lfsr_lane #(
   parameter int            LEN     = 19,
   parameter logic [LEN-1:0] TAPS   = '0,
   parameter int            CLK_BIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic clk_en,
   input  logic d,
   output logic msb,
   output logic clk_bit
);

   logic [LEN-1:0] lane_q;
   logic [LEN-1:0] lane_d;

   always_comb begin
      lane_d = lane_q;
      if (clear) begin
         lane_d = '0;
      end else if (clk_en) begin
         lane_d = {lane_q[LEN-2:0], d ^ (^(lane_q & TAPS))};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_q <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

   assign msb     = lane_q[LEN-1];
   assign clk_bit = lane_q[CLK_BIT];

endmodule

// File: rtl/a5_keystream_ctrl.sv
// A5/1 sequencer: zero-load, key and frame injection, majority mixing, then
// a valid/ready stream of keystream bits ending in a one-cycle done pulse.
module a5_keystream_ctrl
   import a5_pkg::*;
#(
   parameter int KEY_BITS   = KEY_CYCLES,
   parameter int FRAME_BITS = FRAME_CYCLES,
   parameter int MIX_CYCLES = MIX_COUNT,
   parameter int KS_BITS    = KS_COUNT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [KEY_BITS-1:0]   key,
   input  logic [FRAME_BITS-1:0] frame,
   output logic                  busy,
   output logic                  ks_valid,
   input  logic                  ks_ready,
   output logic                  ks_bit,
   output logic                  done
);

   localparam logic [CNT_W-1:0] KEY_RELOAD   = CNT_W'(KEY_BITS - 1);
   localparam logic [CNT_W-1:0] FRAME_RELOAD = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] MIX_RELOAD   = CNT_W'(MIX_CYCLES - 1);
   localparam logic [CNT_W-1:0] KS_RELOAD    = CNT_W'(KS_BITS - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [KEY_BITS-1:0]     key_sr_q, key_sr_d;
   logic [FRAME_BITS-1:0]   frame_sr_q, frame_sr_d;
   logic                    done_q, done_d;

   logic       lane_clear;
   logic [2:0] lane_en;
   logic [2:0] maj_en;
   logic [2:0] lane_msb;
   logic [2:0] lane_clk;
   logic       inj_bit;
   logic       maj_bit;

   // A lane steps under majority clocking only when its clock bit agrees with the majority.
   assign maj_bit = maj3(lane_clk[0], lane_clk[1], lane_clk[2]);
   assign maj_en  = {lane_clk[2] == maj_bit, lane_clk[1] == maj_bit, lane_clk[0] == maj_bit};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      key_sr_d   = key_sr_q;
      frame_sr_d = frame_sr_q;
      done_d     = 1'b0;
      lane_clear = 1'b0;
      lane_en    = 3'b000;
      inj_bit    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LOAD;
               key_sr_d   = key;
               frame_sr_d = frame;
               cnt_d      = '0;
            end
         end
         ST_LOAD: begin
            lane_clear = 1'b1;
            state_d    = ST_KEY;
            cnt_d      = KEY_RELOAD;
         end
         ST_KEY: begin
            lane_en  = 3'b111;
            inj_bit  = key_sr_q[0];
            key_sr_d = key_sr_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_FRAME;
               cnt_d   = FRAME_RELOAD;
            end
         end
         ST_FRAME: begin
            lane_en    = 3'b111;
            inj_bit    = frame_sr_q[0];
            frame_sr_d = frame_sr_q >> 1;
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_MIX;
               cnt_d   = MIX_RELOAD;
            end
         end
         ST_MIX: begin
            lane_en = maj_en;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_STREAM;
               cnt_d   = KS_RELOAD;
            end
         end
         ST_STREAM: begin
            if (ks_ready) begin
               lane_en = maj_en;
               cnt_d   = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         key_sr_q   <= '0;
         frame_sr_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         key_sr_q   <= key_sr_d;
         frame_sr_q <= frame_sr_d;
         done_q     <= done_d;
      end
   end

   a5_lfsr_lane #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
      .clk(clk), .reset(reset), .clear(lane_clear), .clk_en(lane_en[0]),
      .d(inj_bit), .msb(lane_msb[0]), .clk_bit(lane_clk[0])
   );

   a5_lfsr_lane #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
      .clk(clk), .reset(reset), .clear(lane_clear), .clk_en(lane_en[1]),
      .d(inj_bit), .msb(lane_msb[1]), .clk_bit(lane_clk[1])
   );

   a5_lfsr_lane #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
      .clk(clk), .reset(reset), .clear(lane_clear), .clk_en(lane_en[2]),
      .d(inj_bit), .msb(lane_msb[2]), .clk_bit(lane_clk[2])
   );

   assign busy     = (state_q != ST_IDLE);
   assign ks_valid = (state_q == ST_STREAM);
   assign ks_bit   = ^lane_msb;
   assign done     = done_q;

endmodule

// File: tb/tb_a5_keystream_ctrl.sv
// Self-checking bench for a5_keystream_ctrl: a behavioural A5/1 model feeds a
// scoreboard queue; a table of sessions plus reset and back-to-back sequences.
module tb_a5_keystream_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] key;
   logic [21:0] frame;
   logic        busy;
   logic        ks_valid;
   logic        ks_ready;
   logic        ks_bit;
   logic        done;

   int tests_run    = 0;
   int tests_failed = 0;

   logic sb_q[$];

   typedef struct {
      logic [63:0] key;
      logic [21:0] frame;
      bit          rand_ready;
      int          busy_at;
      logic [63:0] alt_key;
      bit          hold_start;
      bit          pre_started;
      int          abort_after;
      int          exp_first_valid;
      int          exp_done;
   } vec_t;

   vec_t vecs[5];
   vec_t hv;

   always #5 clk = ~clk;

   a5_keystream_ctrl dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .key(key),
      .frame(frame),
      .busy(busy),
      .ks_valid(ks_valid),
      .ks_ready(ks_ready),
      .ks_bit(ks_bit),
      .done(done)
   );

   // Reference A5/1: clock-all loading with the injected bit XORed into bit 0,
   // then majority clocking; bit n is read after 101+n majority clocks.
   function automatic logic [227:0] a5_model(input logic [63:0] k, input logic [21:0] f);
      logic [18:0]  r1;
      logic [21:0]  r2;
      logic [22:0]  r3;
      logic [227:0] bits;
      logic         b;
      logic         m;
      r1 = '0; r2 = '0; r3 = '0; bits = '0;
      for (int i = 0; i < 86; i++) begin
         if (i < 64) b = k[i];
         else        b = f[i-64];
         r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ b};
         r2 = {r2[20:0], r2[21] ^ r2[20] ^ b};
         r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ b};
      end
      for (int i = 0; i < 328; i++) begin
         m = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
         if (r1[8] == m)  r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13]};
         if (r2[10] == m) r2 = {r2[20:0], r2[21] ^ r2[20]};
         if (r3[10] == m) r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7]};
         if (i >= 100) bits[i-100] = r1[18] ^ r2[21] ^ r3[22];
      end
      return bits;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [227:0] exp_bits;
      logic         exp_bit;
      logic         held_bit;
      int           rel;
      int           hs;
      bit           finished;
      bit           stall;
      bit           seen_valid;
      exp_bits = a5_model(v.key, v.frame);
      for (int i = 0; i < 228; i++) sb_q.push_back(exp_bits[i]);
      if (!v.pre_started) begin
         @(negedge clk);
         key      = v.key;
         frame    = v.frame;
         start    = 1'b1;
         ks_ready = 1'b1;
      end
      rel = 0; hs = 0; finished = 0; stall = 0; seen_valid = 0; held_bit = 1'b0;
      while (!finished && rel < 3000) begin
         @(negedge clk);
         rel++;
         start = v.hold_start;
         if (rel == v.busy_at) begin
            start = 1'b1;
            key   = v.alt_key;
         end
         if (ks_valid && !seen_valid) begin
            seen_valid = 1;
            checkOutput("first_valid_cycle", 64'(rel), 64'(v.exp_first_valid));
         end
         if (stall) begin
            checkOutput("stall_valid", {63'd0, ks_valid}, 64'd1);
            checkOutput("stall_bit", {63'd0, ks_bit}, {63'd0, held_bit});
         end
         if (v.abort_after >= 0 && hs == v.abort_after) begin
            finished = 1;
         end else begin
            ks_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stall = 0;
            if (ks_valid && ks_ready) begin
               if (sb_q.size() == 0) begin
                  tests_run++; tests_failed++;
                  $display("[TB] FAIL sb_underflow: extra handshake %0d, expected none", hs);
               end else begin
                  exp_bit = sb_q.pop_front();
                  checkOutput($sformatf("ks_bit[%0d]", hs), {63'd0, ks_bit}, {63'd0, exp_bit});
               end
               hs++;
            end else if (ks_valid) begin
               stall    = 1;
               held_bit = ks_bit;
            end
            if (done) begin
               finished = 1;
               if (v.exp_done > 0) checkOutput("done_cycle", 64'(rel), 64'(v.exp_done));
               checkOutput("done_handshakes", 64'(hs), 64'd228);
               checkOutput("done_busy", {63'd0, busy}, 64'd0);
               checkOutput("done_valid", {63'd0, ks_valid}, 64'd0);
               checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
               if (v.hold_start) key = v.alt_key;
            end
         end
      end
      if (!finished) begin
         tests_run++; tests_failed++;
         $display("[TB] FAIL session_timeout: got no done after %0d cycles, expected done", rel);
      end
      if (v.abort_after < 0 && !v.hold_start && finished) begin
         @(negedge clk);
         checkOutput("done_pulse_width", {63'd0, done}, 64'd0);
      end
      sb_q.delete();
   endtask

   function automatic vec_t mkVec(input logic [63:0] k, input logic [21:0] f, input bit rr,
                                  input int busy_at, input logic [63:0] alt, input int exp_done);
      vec_t v;
      v.key = k; v.frame = f; v.rand_ready = rr; v.busy_at = busy_at; v.alt_key = alt;
      v.hold_start = 0; v.pre_started = 0; v.abort_after = -1;
      v.exp_first_valid = 189; v.exp_done = exp_done;
      return v;
   endfunction

   initial begin
      reset = 1'b1; start = 1'b0; key = '0; frame = '0; ks_ready = 1'b0;
      #1;
      checkOutput("reset_busy", {63'd0, busy}, 64'd0);
      checkOutput("reset_valid", {63'd0, ks_valid}, 64'd0);
      checkOutput("reset_done", {63'd0, done}, 64'd0);
      checkOutput("reset_ks_bit", {63'd0, ks_bit}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      vecs[0] = mkVec(64'h0, 22'h0, 0, -1, 64'h0, 417);
      vecs[1] = mkVec(64'h1223456789ABCDEF, 22'h134, 0, -1, 64'h0, 417);
      vecs[2] = mkVec(64'h1223456789ABCDEF, 22'h134, 1, -1, 64'h0, -1);
      vecs[3] = mkVec(64'h1223456789ABCDEF, 22'h134, 0, 50, 64'hDEADBEEF01234567, 417);
      vecs[4] = mkVec(64'hFFFFFFFFFFFFFFFF, 22'h3FFFFF, 0, -1, 64'h0, 417);

      for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

      // Reset after 10 delivered bits, then a fresh session from bit 0.
      hv = mkVec(64'h1223456789ABCDEF, 22'h134, 0, -1, 64'h0, 417);
      hv.abort_after = 10;
      applyStimulus(hv);
      reset = 1'b1;
      #1;
      checkOutput("midreset_busy", {63'd0, busy}, 64'd0);
      checkOutput("midreset_valid", {63'd0, ks_valid}, 64'd0);
      checkOutput("midreset_done", {63'd0, done}, 64'd0);
      checkOutput("midreset_ks_bit", {63'd0, ks_bit}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(mkVec(64'h1223456789ABCDEF, 22'h134, 0, -1, 64'h0, 417));

      // start held high across done: next session begins in the done cycle.
      hv = mkVec(64'h1223456789ABCDEF, 22'h134, 0, -1, 64'h0F1E2D3C4B5A6978, 417);
      hv.hold_start = 1;
      applyStimulus(hv);
      hv = mkVec(64'h0F1E2D3C4B5A6978, 22'h134, 0, -1, 64'h0, 417);
      hv.pre_started = 1;
      applyStimulus(hv);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
